// File: rtl/nios2_qsys_dct_pkg.sv
// Shared widths and FSM state type for the debug control trace packer.
package nios2_qsys_dct_pkg;

   localparam int unsigned ATOM_W = 3;
   localparam int unsigned SLOTS  = 10;
   localparam int unsigned BUF_W  = ATOM_W * SLOTS;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DROP_W = 16;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FLUSH = 2'd1,
      ENDED = 2'd2
   } state_e;

endpackage

// File: rtl/nios2_qsys_dct_packer_if.sv
// Atom input, frame output and end-of-test status bundle of the DCT packer.
// DCT_DROP_ON_FULL_EN adds the drop_count status signal.
interface nios2_qsys_dct_packer_if;
   import nios2_qsys_dct_pkg::*;

   logic              atom_valid;
   logic [ATOM_W-1:0] atom_data;
   logic              atom_ready;
   logic              flush_req;
   logic              frame_valid;
   logic              frame_ready;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              test_ending;
   logic              test_has_ended;
`ifdef DCT_DROP_ON_FULL_EN
   logic [DROP_W-1:0] drop_count;
`endif

   // Packer side
   modport master (
      input  atom_valid, atom_data, flush_req, frame_ready,
      output atom_ready, frame_valid, dct_buffer, dct_count,
`ifdef DCT_DROP_ON_FULL_EN
      output drop_count,
`endif
      output test_ending, test_has_ended
   );

   // Trace source / sink / monitor side
   modport slave (
      output atom_valid, atom_data, flush_req, frame_ready,
      input  atom_ready, frame_valid, dct_buffer, dct_count,
`ifdef DCT_DROP_ON_FULL_EN
      input  drop_count,
`endif
      input  test_ending, test_has_ended
   );

endinterface

// File: rtl/nios2_qsys_dct_outreg.sv
// Single-entry valid/ready frame holding register; out_free_c says it can take a frame this cycle.
module nios2_qsys_dct_outreg
   import nios2_qsys_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BUF_W-1:0] load_buf,
   input  logic [CNT_W-1:0] load_cnt,
   input  logic             frame_ready,
   output logic             frame_valid,
   output logic [BUF_W-1:0] dct_buffer,
   output logic [CNT_W-1:0] dct_count,
   output logic             out_free_c
);

   logic             frame_valid_q, frame_valid_d;
   logic [BUF_W-1:0] dct_buffer_q, dct_buffer_d;
   logic [CNT_W-1:0] dct_count_q, dct_count_d;

   assign out_free_c = !frame_valid_q || frame_ready;

   // A load in the same cycle as a drain replaces the frame with no bubble
   always_comb begin
      frame_valid_d = frame_valid_q;
      dct_buffer_d  = dct_buffer_q;
      dct_count_d   = dct_count_q;
      if (load) begin
         frame_valid_d = 1'b1;
         dct_buffer_d  = load_buf;
         dct_count_d   = load_cnt;
      end else if (frame_ready) begin
         frame_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_valid_q <= 1'b0;
         dct_buffer_q  <= '0;
         dct_count_q   <= '0;
      end else begin
         frame_valid_q <= frame_valid_d;
         dct_buffer_q  <= dct_buffer_d;
         dct_count_q   <= dct_count_d;
      end
   end

   assign frame_valid = frame_valid_q;
   assign dct_buffer  = dct_buffer_q;
   assign dct_count   = dct_count_q;

endmodule

// File: rtl/nios2_qsys_dct_packer.sv
// Packs 3-bit trace atoms into 30-bit DCT frames and sequences end-of-test flush.
// DCT_DROP_ON_FULL_EN: keep accepting when full and count the dropped atoms.
module nios2_qsys_dct_packer
   import nios2_qsys_dct_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   nios2_qsys_dct_packer_if.master bus
);

   state_e           state_q, state_d;
   logic [BUF_W-1:0] acc_buf_q, acc_buf_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
`ifdef DCT_DROP_ON_FULL_EN
   logic [DROP_W-1:0] drop_count_q, drop_count_d;
`endif

   logic acc_full_c;
   logic atom_ready_c;
   logic accept_c;
   logic transfer_c;
   logic out_free_c;
   logic frame_valid;

   assign acc_full_c = (acc_cnt_q == CNT_W'(SLOTS));

   // Next state, accumulator update and transfer decision
   always_comb begin
      state_d      = state_q;
      acc_buf_d    = acc_buf_q;
      acc_cnt_d    = acc_cnt_q;
      atom_ready_c = 1'b0;
      transfer_c   = 1'b0;
`ifdef DCT_DROP_ON_FULL_EN
      drop_count_d = drop_count_q;
`endif

      unique case (state_q)
         FILL: begin
`ifdef DCT_DROP_ON_FULL_EN
            atom_ready_c = 1'b1;
`else
            atom_ready_c = !acc_full_c;
`endif
            transfer_c = acc_full_c && out_free_c;
            if (bus.flush_req) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            transfer_c = (acc_cnt_q != '0) && out_free_c;
            if ((acc_cnt_q == '0) && !frame_valid) begin
               state_d = ENDED;
            end
         end
         ENDED: begin
         end
         default: begin
            state_d = FILL;
         end
      endcase

      accept_c = bus.atom_valid && atom_ready_c;

      if (accept_c && !acc_full_c) begin
         for (int unsigned k = 0; k < SLOTS; k++) begin
            if (acc_cnt_q == CNT_W'(k)) begin
               acc_buf_d[k*ATOM_W +: ATOM_W] = bus.atom_data;
            end
         end
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end

`ifdef DCT_DROP_ON_FULL_EN
      if (accept_c && acc_full_c && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + DROP_W'(1);
      end
`endif

      // Clearing to zero keeps unused slots of a later partial frame at zero
      if (transfer_c) begin
         acc_buf_d = '0;
         acc_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FILL;
         acc_buf_q <= '0;
         acc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_buf_q <= acc_buf_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

`ifdef DCT_DROP_ON_FULL_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_count_q <= '0;
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   assign bus.drop_count = drop_count_q;
`endif

   nios2_qsys_dct_outreg u_outreg (
      .clk         (clk),
      .reset       (reset),
      .load        (transfer_c),
      .load_buf    (acc_buf_q),
      .load_cnt    (acc_cnt_q),
      .frame_ready (bus.frame_ready),
      .frame_valid (frame_valid),
      .dct_buffer  (bus.dct_buffer),
      .dct_count   (bus.dct_count),
      .out_free_c  (out_free_c)
   );

   assign bus.frame_valid    = frame_valid;
   assign bus.atom_ready     = atom_ready_c;
   assign bus.test_ending    = (state_q == FLUSH);
   assign bus.test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_nios2_qsys_dct_packer.sv
// Self-checking bench for nios2_qsys_dct_packer: queue-based reference model plus directed literal checks.
module tb_nios2_qsys_dct_packer;
   import nios2_qsys_dct_pkg::*;

`ifdef DCT_DROP_ON_FULL_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   nios2_qsys_dct_packer_if bus();

   nios2_qsys_dct_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_deliv = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_phase;     // 0 filling, 1 flushing, 2 ended
   int          m_acc[$];    // atoms accepted but not yet framed
   bit          m_has_out;
   logic [29:0] m_buf;
   int          m_cnt;
   int          m_drop;

   function automatic logic [29:0] pack(input int q[$]);
      logic [29:0] f;
      f = '0;
      foreach (q[i]) f = f | (30'(q[i]) << (3 * i));
      return f;
   endfunction

   function automatic bit exp_ready();
      return (m_phase == 0) && ((m_acc.size() < SLOTS) || DROP);
   endfunction

   initial begin
      m_phase = 0; m_has_out = 0; m_buf = '0; m_cnt = 0; m_drop = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_phase = 0; m_acc.delete(); m_has_out = 0; m_buf = '0; m_cnt = 0; m_drop = 0;
         end else begin
            int sz, nph;
            bit free, acc, xfer;
            sz   = m_acc.size();
            free = !m_has_out || bus.frame_ready;
            acc  = bus.atom_valid && exp_ready();
            xfer = ((m_phase == 0) && (sz == SLOTS) && free) ||
                   ((m_phase == 1) && (sz > 0) && free);
            nph = m_phase;
            if ((m_phase == 0) && bus.flush_req) nph = 1;
            else if ((m_phase == 1) && (sz == 0) && !m_has_out) nph = 2;
            if (xfer) begin
               m_buf = pack(m_acc);
               m_cnt = sz;
               m_acc.delete();
            end
            if (acc) begin
               if (sz < SLOTS) m_acc.push_back(int'(bus.atom_data));
               else if (m_drop < 65535) m_drop++;
            end
            if (xfer) m_has_out = 1;
            else if (bus.frame_ready) m_has_out = 0;
            m_phase = nph;
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("atom_ready", bus.atom_ready, exp_ready());
            chk("frame_valid", bus.frame_valid, m_has_out);
            if (m_has_out) begin
               chk("dct_buffer", bus.dct_buffer, m_buf);
               chk("dct_count", bus.dct_count, m_cnt);
            end
            chk("test_ending", bus.test_ending, m_phase == 1);
            chk("test_has_ended", bus.test_has_ended, m_phase == 2);
`ifdef DCT_DROP_ON_FULL_EN
            chk("drop_count", bus.drop_count, m_drop);
`endif
            if (bus.frame_valid && bus.frame_ready) n_deliv++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.atom_valid = 1'b0;
      bus.flush_req = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_atom_ready"}, bus.atom_ready, 1);
      chk({tag, "_frame_valid"}, bus.frame_valid, 0);
      chk({tag, "_dct_buffer"}, bus.dct_buffer, 0);
      chk({tag, "_dct_count"}, bus.dct_count, 0);
      chk({tag, "_test_ending"}, bus.test_ending, 0);
      chk({tag, "_test_has_ended"}, bus.test_has_ended, 0);
   endtask

   // Offer random atoms until total accepted reaches target or the cycle budget runs out
   task automatic send_until(inout int acc_n, input int target, input int budget);
      for (int c = 0; c < budget && acc_n < target; c++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = 3'($urandom);
         if (bus.atom_ready) acc_n++;
         step();
      end
      bus.atom_valid = 1'b0;
   endtask

   initial begin
      int t1[10];
      int acc_n, d0;
      bit found, saw_fv, all_ready;

      reset = 1'b1;
      bus.atom_valid = 1'b0;
      bus.atom_data = '0;
      bus.flush_req = 1'b0;
      bus.frame_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("por");
      step();
      reset = 1'b0;

      // Full frame from a known atom sequence
      t1 = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
      bus.frame_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = 3'(t1[i]);
         step();
      end
      bus.atom_valid = 1'b0;
      chk("t1_fv_T1", bus.frame_valid, 0);
      step();
      chk("t1_fv_T2", bus.frame_valid, 1);
      chk("t1_buf", bus.dct_buffer, 32'h111F58D1);
      chk("t1_cnt", bus.dct_count, 10);
      step();

      // Backpressure: 25 atoms with the sink stalled
      bus.frame_ready = 1'b0;
      acc_n = 0;
      send_until(acc_n, 25, 40);
      chk("t2_stall_accepts", acc_n, 20);
      chk("t2_stall_ready", bus.atom_ready, 0);
      d0 = n_deliv;
      bus.frame_ready = 1'b1;
      send_until(acc_n, 25, 40);
      repeat (5) step();
      chk("t2_frames", n_deliv - d0, 2);
      chk("t2_accepts", acc_n, 25);
      send_until(acc_n, 30, 40);
      repeat (4) step();
      chk("t2_frames_total", n_deliv - d0, 3);

      // Random traffic with random sink stalls
      for (int c = 0; c < 400; c++) begin
         bus.atom_valid  = ($urandom % 4) != 0;
         bus.atom_data   = 3'($urandom);
         bus.frame_ready = ($urandom % 3) != 0;
         step();
      end
      bus.atom_valid = 1'b0;
      bus.frame_ready = 1'b1;
      repeat (4) step();

      // Reset with a frame pending and 7 atoms accumulated
      do_reset();
      bus.frame_ready = 1'b0;
      acc_n = 0;
      send_until(acc_n, 17, 40);
      step();
      chk("t5_pending", bus.frame_valid, 1);
      #1 reset = 1'b1;
      #1 chk_reset_vals("t5_async");
      step();
      step();
      reset = 1'b0;
      bus.frame_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = (i == 9) ? 3'd1 : 3'd0;
         step();
      end
      bus.atom_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         if (bus.frame_valid) found = 1'b1;
         else step();
      end
      chk("t5_frame_seen", found, 1);
      chk("t5_clean_buf", bus.dct_buffer, 32'h08000000);
      chk("t5_clean_cnt", bus.dct_count, 10);
      step();

      // Partial frame on flush
      do_reset();
      bus.frame_ready = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = 3'(i);
         step();
      end
      bus.atom_valid = 1'b0;
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      chk("t3_ending", bus.test_ending, 1);
      step();
      chk("t3_fv", bus.frame_valid, 1);
      chk("t3_buf", bus.dct_buffer, 32'h1F5);
      chk("t3_cnt", bus.dct_count, 3);
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      step();
      chk("t3_hold", bus.frame_valid, 1);
      bus.frame_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 5 && !found; c++) begin
         if (bus.test_has_ended) found = 1'b1;
         else step();
      end
      chk("t3_ended", bus.test_has_ended, 1);
      chk("t3_ending_off", bus.test_ending, 0);
      chk("t3_ready_off", bus.atom_ready, 0);

      // Flush with nothing buffered
      do_reset();
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      saw_fv = 1'b0;
      for (int c = 0; c < 2; c++) begin
         if (bus.frame_valid) saw_fv = 1'b1;
         step();
      end
      chk("t4_ended", bus.test_has_ended, 1);
      chk("t4_no_frame", saw_fv, 0);
      bus.atom_valid = 1'b1;
      repeat (3) step();
      bus.atom_valid = 1'b0;
      chk("t4_ready_off", bus.atom_ready, 0);
      chk("t4_sticky", bus.test_has_ended, 1);

`ifdef DCT_DROP_ON_FULL_EN
      // Drop mode: 23 atoms into a stalled sink
      do_reset();
      bus.frame_ready = 1'b0;
      all_ready = 1'b1;
      for (int i = 0; i < 23; i++) begin
         bus.atom_valid = 1'b1;
         bus.atom_data  = 3'($urandom);
         if (!bus.atom_ready) all_ready = 1'b0;
         step();
      end
      bus.atom_valid = 1'b0;
      step();
      chk("drop_ready", all_ready, 1);
      chk("drop_count_lit", bus.drop_count, 3);
`else
      all_ready = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nios2_qsys_dct_packer.md
Name: nios2_qsys_dct_packer

Overview:
- Producer side of the debug control trace (DCT) stream.
- Packs 3-bit trace atoms from the OCI trace logic into 30-bit frames with a slot count.
- Hands frames to the trace sink with a valid/ready handshake.
- Sequences end-of-test: `test_ending` while draining, then `test_has_ended`. These four signals are exactly what the OCI test-bench monitor consumes.

Parameters:
- ATOM_W, 3, bits per trace atom
- SLOTS, 10, atoms per full frame
- BUF_W, 30, frame width; localparam, must equal ATOM_W*SLOTS
- CNT_W, 4, count width; must hold SLOTS

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- atom_valid  in  1  atom offered
- atom_data  in  3  atom payload
- atom_ready  out  1  atom accepted when atom_valid && atom_ready
- flush_req  in  1  single-cycle end-of-test request
- frame_valid  out  1  dct_buffer/dct_count hold a frame
- frame_ready  in  1  sink accepts the frame
- dct_buffer  out  30  packed frame; slot k occupies bits [3k+2:3k], slot 0 first; unused slots zero
- dct_count  out  4  valid slots in frame, 1..10
- test_ending  out  1  flush in progress
- test_has_ended  out  1  flush complete; sticky until reset

Behaviour:
- Reset (asynchronous assert, all flops cleared):
  - outputs: atom_ready=1, frame_valid=0, dct_buffer=0, dct_count=0, test_ending=0, test_has_ended=0
  - state=FILL; accumulator empty (acc_cnt=0)
  - reset asserted mid-frame or mid-flush discards everything; no partial frame is emitted.
- Registers:
  - accumulator: acc_buf[29:0], acc_cnt[3:0]
  - output register: dct_buffer, dct_count, frame_valid
- out_free = !frame_valid || frame_ready.
- Accept:
  - atom written to slot acc_cnt; acc_cnt increments next cycle.
  - atom_ready = (state==FILL) && acc_cnt<SLOTS.
- Transfer (FILL state):
  - condition: acc_cnt==SLOTS && out_free.
  - copies acc_buf/acc_cnt into the output register, sets frame_valid, clears the accumulator.
  - latency: 10th atom accepted in cycle T → acc_cnt=10 at T+1 → frame_valid at T+2 (sink ready).
- Output handshake:
  - frame_valid stays high with dct_buffer/dct_count stable until frame_ready.
  - a simultaneous drain and transfer in the same cycle is legal: the new frame replaces the old one with no bubble.
- Backpressure: accumulator full while the output is stalled → atom_ready=0. No atom is lost.
- States:
  - FILL: normal accept/transfer; flush_req → FLUSH. An atom accepted in the same cycle as flush_req is included in the flush.
  - FLUSH: test_ending=1, atom_ready=0. When out_free and acc_cnt>0, transfer the partial frame (dct_count=acc_cnt). Once acc_cnt==0 and frame_valid==0 → ENDED.
  - ENDED: test_ending=0, test_has_ended=1, atom_ready=0; terminal until reset.
- Boundaries:
  - flush_req with an empty accumulator and idle output → ENDED after 1 cycle in FLUSH; no frame emitted.
  - flush_req while in FLUSH or ENDED is ignored.
  - dct_count is never 0 while frame_valid=1.

Optional Feature:
- Macro: DCT_DROP_ON_FULL_EN.
- Defined:
  - atom_ready=1 in FILL even when the accumulator is full.
  - atoms arriving at acc_cnt==SLOTS are dropped.
  - adds port drop_count out 16: saturating count of dropped atoms, cleared by reset.
- Undefined: backpressure as specified above; no drop_count port.

Decomposition:
- Package nios2_qsys_dct_pkg:
  - ATOM_W, SLOTS, BUF_W, CNT_W
  - state enum {FILL, FLUSH, ENDED}
- Sub-module nios2_qsys_dct_outreg: single-entry valid/ready output register with out_free generation.
- Packing and the FSM stay in the top level.

Test Plan:
- Atoms 1,2,3,4,5,6,7,0,1,2 on consecutive cycles, frame_ready=1 → one frame, dct_buffer=0x111F58D1, dct_count=10, frame_valid 2 cycles after the 10th accept.
- Hold frame_ready=0, send 25 atoms → atom_ready drops after the 20th accept (one frame held, one in accumulator). Release frame_ready → two frames delivered in order, then the remaining 5 atoms are accepted.
- Atoms 5,6,7 then flush_req → test_ending=1, frame dct_buffer=0x1F5, dct_count=3. After the sink accepts it, test_has_ended=1 and test_ending=0.
- flush_req right after reset → no frame_valid pulse, test_has_ended=1 within 2 cycles, atom_ready=0 thereafter.
- Assert reset with 7 atoms accumulated and a frame pending → all outputs return to reset values immediately. Post-reset 10 atoms produce a clean frame with no stale slots.
- DCT_DROP_ON_FULL_EN, frame_ready=0, 23 atoms → atom_ready stays 1, drop_count=3.
